// File: rtl/led_pattern_gen.sv
// Purpose : LED pattern generator (binary count, bounce, Gray count, breathe) behind a 2^SLOW prescaler.
// Latency : LEDS is registered; a step taken on the TICK edge is visible the following cycle.
// Backpres: none; PAUSE freezes pattern advance while the prescaler keeps running.
//
// Ports : CLK, RESET (sync, active-high), MODE[1:0] (0 count, 1 bounce, 2 Gray, 3 breathe),
//         PAUSE, TICK (prescaler wrap pulse), LEDS[NLEDS-1:0].
// Config: define LED_PATTERN_PWM_EN to build the PWM breathe mode; without it MODE 3 is a down-counter.
module led_pattern_gen #(
  parameter int NLEDS    = 5,
  parameter int SLOW     = 21,
  parameter int PWM_BITS = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       MODE,
  input  logic             PAUSE,
  output logic             TICK,
  output logic [NLEDS-1:0] LEDS
);

  localparam int POS_W = (NLEDS > 1) ? $clog2(NLEDS) : 1;

  localparam logic [1:0] M_COUNT   = 2'd0;
  localparam logic [1:0] M_BOUNCE  = 2'd1;
  localparam logic [1:0] M_GRAY    = 2'd2;
  localparam logic [1:0] M_BREATHE = 2'd3;

  // Elaboration-time parameter range checks.
  generate
    if (NLEDS < 1 || NLEDS > 16)       begin : g_bad_nleds $error("NLEDS out of range"); end
    if (SLOW < 1 || SLOW > 26)         begin : g_bad_slow  $error("SLOW out of range"); end
    if (PWM_BITS < 2 || PWM_BITS > 8)  begin : g_bad_pwm   $error("PWM_BITS out of range"); end
  endgenerate

  logic [SLOW-1:0]  presc_q, presc_d;
  logic [1:0]       cur_mode_q, cur_mode_d;
  logic [NLEDS-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_down_q, dir_down_d;
  logic [NLEDS-1:0] leds_q, leds_d;
`ifdef LED_PATTERN_PWM_EN
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                duty_fall_q, duty_fall_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
`endif

  logic step;
  logic mode_chg;
  logic advance;

  assign TICK     = (presc_q == {SLOW{1'b1}});
  assign step     = TICK & ~PAUSE;
  // A differing MODE sample only reinitialises the new mode; no step is taken on that edge.
  assign mode_chg = step & (MODE != cur_mode_q);
  assign advance  = step & (MODE == cur_mode_q);
  assign LEDS     = leds_q;

  always_comb begin
    presc_d    = presc_q + SLOW'(1);
    cur_mode_d = cur_mode_q;
    cnt_d      = cnt_q;
    pos_d      = pos_q;
    dir_down_d = dir_down_q;
    leds_d     = leds_q;
`ifdef LED_PATTERN_PWM_EN
    duty_d      = duty_q;
    duty_fall_d = duty_fall_q;
    pwm_d       = pwm_q + PWM_BITS'(1);
`endif

    if (mode_chg) begin
      cur_mode_d = MODE;
      case (MODE)
        M_BOUNCE: begin
          pos_d      = '0;
          dir_down_d = 1'b0;
          leds_d     = NLEDS'(1);
        end
        M_BREATHE: begin
`ifdef LED_PATTERN_PWM_EN
          duty_d      = '0;
          duty_fall_d = 1'b0;
`else
          cnt_d       = '0;
`endif
          leds_d = '0;
        end
        default: begin
          cnt_d  = '0;
          leds_d = '0;
        end
      endcase
    end else if (advance) begin
      case (cur_mode_q)
        M_COUNT: begin
          cnt_d  = cnt_q + NLEDS'(1);
          leds_d = cnt_d;
        end
        M_BOUNCE: begin
          // End positions turn around immediately so they are shown only once.
          if (NLEDS > 1) begin
            if (!dir_down_q) begin
              if (pos_q == POS_W'(NLEDS - 1)) begin
                dir_down_d = 1'b1;
                pos_d      = pos_q - POS_W'(1);
              end else begin
                pos_d = pos_q + POS_W'(1);
              end
            end else begin
              if (pos_q == '0) begin
                dir_down_d = 1'b0;
                pos_d      = POS_W'(1);
              end else begin
                pos_d = pos_q - POS_W'(1);
              end
            end
          end
          leds_d = NLEDS'(1) << pos_d;
        end
        M_GRAY: begin
          cnt_d  = cnt_q + NLEDS'(1);
          leds_d = cnt_d ^ (cnt_d >> 1);
        end
        default: begin
`ifdef LED_PATTERN_PWM_EN
          // Triangle ramp; endpoints reverse direction without repeating.
          if (!duty_fall_q) begin
            if (duty_q == {PWM_BITS{1'b1}}) begin
              duty_fall_d = 1'b1;
              duty_d      = duty_q - PWM_BITS'(1);
            end else begin
              duty_d = duty_q + PWM_BITS'(1);
            end
          end else begin
            if (duty_q == '0) begin
              duty_fall_d = 1'b0;
              duty_d      = duty_q + PWM_BITS'(1);
            end else begin
              duty_d = duty_q - PWM_BITS'(1);
            end
          end
`else
          cnt_d  = cnt_q - NLEDS'(1);
          leds_d = cnt_d;
`endif
        end
      endcase
    end

`ifdef LED_PATTERN_PWM_EN
    // In breathe mode the LEDs follow the previous cycle's pwm/duty compare every clock.
    if (!mode_chg && cur_mode_q == M_BREATHE) begin
      leds_d = {NLEDS{pwm_q < duty_q}};
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q    <= '0;
      cur_mode_q <= M_COUNT;
      cnt_q      <= '0;
      pos_q      <= '0;
      dir_down_q <= 1'b0;
      leds_q     <= '0;
`ifdef LED_PATTERN_PWM_EN
      duty_q      <= '0;
      duty_fall_q <= 1'b0;
      pwm_q       <= '0;
`endif
    end else begin
      presc_q    <= presc_d;
      cur_mode_q <= cur_mode_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      dir_down_q <= dir_down_d;
      leds_q     <= leds_d;
`ifdef LED_PATTERN_PWM_EN
      duty_q      <= duty_d;
      duty_fall_q <= duty_fall_d;
      pwm_q       <= pwm_d;
`endif
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Purpose : self-checking bench for led_pattern_gen (SLOW=2, NLEDS=5, PWM_BITS=3).
// Latency : expected LED values are queued per step and popped on the cycle after each predicted TICK.
// Backpres: none; PAUSE and RESET are driven directly by the stimulus sequence.
module tb_led_pattern_gen;
  localparam int NL = 5;
  localparam int SL = 2;
  localparam int PB = 3;
  localparam int PRESC_MAX = (1 << SL) - 1;
  localparam int PWM_MOD   = (1 << PB);

  logic          CLK = 1'b0;
  logic          RESET;
  logic [1:0]    MODE;
  logic          PAUSE;
  logic          TICK;
  logic [NL-1:0] LEDS;

  always #5 CLK = ~CLK;

  led_pattern_gen #(.NLEDS(NL), .SLOW(SL), .PWM_BITS(PB)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .MODE (MODE),
    .PAUSE(PAUSE),
    .TICK (TICK),
    .LEDS (LEDS)
  );

  int checks = 0;
  int errors = 0;

  logic [NL-1:0] exp_q[$];
  int            duty_q[$];
  logic [NL-1:0] last_exp = '0;
  int            presc_m = 0;
  int            pwm_m = 0;
  int            duty_m = 0;
  bit            breathe_m = 1'b0;
  int            steps_seen = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: predict step from the bench's own prescaler, then compare at the falling edge.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bit            stepped;
      logic [NL-1:0] bexp;
      stepped = (presc_m == PRESC_MAX) && !PAUSE && !RESET;
      bexp    = (pwm_m < duty_m) ? '1 : '0;
      @(posedge CLK);
      if (RESET) begin
        presc_m = 0;
        pwm_m   = 0;
      end else begin
        presc_m = (presc_m + 1) % (PRESC_MAX + 1);
        pwm_m   = (pwm_m + 1) % PWM_MOD;
      end
      @(negedge CLK);
      if (RESET) begin
        last_exp = '0;
      end else if (breathe_m) begin
        last_exp = bexp;
        if (stepped) begin
          steps_seen++;
          if (duty_q.size() == 0) check("duty_sb_empty", 32'(duty_q.size()), 32'd1);
          else duty_m = duty_q.pop_front();
        end
      end else if (stepped) begin
        steps_seen++;
        if (exp_q.size() == 0) check("sb_empty", 32'(exp_q.size()), 32'd1);
        else last_exp = exp_q.pop_front();
      end
      check("leds", 32'(LEDS), 32'(last_exp));
      check("tick", 32'(TICK), 32'(presc_m == PRESC_MAX));
    end
  endtask

  task automatic run_steps(input int n);
    int start;
    int budget;
    start  = steps_seen;
    budget = 0;
    while ((steps_seen - start) < n && budget < 4 * n + 8) begin
      run_cycles(1);
      budget++;
    end
    check("step_count", 32'(steps_seen - start), 32'(n));
  endtask

  task automatic push_list(input int vals[$]);
    foreach (vals[i]) exp_q.push_back(NL'(vals[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bounce_seq[$];
    int gray_seq[$];
    bounce_seq = '{1, 2, 4, 8, 16, 8, 4, 2, 1, 2};
    gray_seq   = '{0, 1, 3, 2, 6, 7, 5, 4};

    // Reset held three cycles.
    RESET = 1'b1;
    MODE  = 2'd0;
    PAUSE = 1'b0;
    @(negedge CLK);
    run_cycles(3);

    // Count mode from reset, full wrap 31 -> 0.
    RESET = 1'b0;
    for (int v = 1; v <= 32; v++) exp_q.push_back(NL'(v));
    run_steps(32);

    // Bounce: first step is the mode switch.
    MODE = 2'd1;
    push_list(bounce_seq);
    run_steps(10);

    // Gray.
    MODE = 2'd2;
    push_list(gray_seq);
    run_steps(8);

    // Back to count, then pause across three ticks.
    MODE = 2'd0;
    push_list('{0, 1, 2});
    run_steps(3);
    PAUSE = 1'b1;
    run_cycles(12);
    PAUSE = 1'b0;
    exp_q.push_back(NL'(3));
    run_steps(1);
    run_cycles(3);

    // Reset coinciding with TICK wins over the step.
    while (presc_m != PRESC_MAX) run_cycles(1);
    RESET = 1'b1;
    run_cycles(1);
    RESET = 1'b0;
    push_list('{1, 2});
    run_steps(2);

    // A MODE glitch that reverts before the next tick is ignored.
    MODE = 2'd1;
    run_cycles(2);
    MODE = 2'd0;
    exp_q.push_back(NL'(3));
    run_steps(1);

`ifdef LED_PATTERN_PWM_EN
    MODE = 2'd3;
    exp_q.push_back(NL'(0));
    run_steps(1);
    breathe_m = 1'b1;
    duty_m    = 0;
    for (int d = 1; d <= 7; d++) duty_q.push_back(d);
    for (int d = 6; d >= 0; d--) duty_q.push_back(d);
    duty_q.push_back(1);
    run_steps(15);
    run_cycles(3);
    RESET     = 1'b1;
    breathe_m = 1'b0;
    run_cycles(1);
    RESET = 1'b0;
`else
    // Down-counter in place of breathe.
    MODE = 2'd3;
    push_list('{0, 31, 30, 29});
    run_steps(4);
    MODE = 2'd0;
    push_list('{0, 1});
    run_steps(2);
`endif

    check("sb_left", 32'(exp_q.size() + duty_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator: a successor to the fixed 5-bit slow blinker, with configurable LED count and prescaler depth and four selectable display modes. It sits between the board clock/reset and the LED pins in FPGA bring-up designs. It gives a visible heartbeat and a pin/mapping check without a soft CPU.

## Interface
- `NLEDS`, default 5: number of LED outputs, range 1..16.
- `SLOW`, default 21: prescaler width; one pattern step every 2^SLOW clocks, range 1..26.
- `PWM_BITS`, default 4: breathing duty resolution, range 2..8.

Ports:
- `CLK`, in, 1: system clock.
- `RESET`, in, 1: synchronous, active-high reset.
- `MODE`, in, 2: pattern select. 0 = binary count, 1 = bounce, 2 = Gray count, 3 = breathe.
- `PAUSE`, in, 1: freezes pattern advance while high.
- `TICK`, out, 1: one-cycle pulse, high when the prescaler wraps.
- `LEDS`, out, NLEDS: registered LED drive.

## Operation
- Prescaler `presc` (SLOW bits) increments every clock and wraps at 2^SLOW-1 to 0. It runs regardless of `PAUSE`.
- `TICK` is combinational: `presc == 2^SLOW-1`.
- Step event = `TICK & ~PAUSE`. Pattern state changes only on a step event. The one exception is the PWM counter in breathe mode.
- `MODE` is sampled only on step events into `cur_mode`.
  - If the sample differs from `cur_mode`, the new mode's state is reinitialised on that edge. No step is taken.
  - If it matches, the current mode advances one step.
- Modes:
  - **Count (0):** `cnt` (NLEDS bits) increments and wraps 2^NLEDS-1 → 0. `LEDS = cnt`.
  - **Bounce (1):** position `pos` with direction `dir`. `LEDS = 1 << pos`. Sequence 0,1,…,NLEDS-1,NLEDS-2,…,0,1,…; end positions are not repeated. With NLEDS=1, `pos` stays 0. Init: `pos = 0`, `dir = up`.
  - **Gray (2):** `cnt` increments as in Count. `LEDS = cnt ^ (cnt >> 1)`. Init `cnt = 0`.
  - **Breathe (3):** duty `duty` (PWM_BITS bits) ramps 0 → 2^PWM_BITS-1 → 0 one step per step event; endpoints are not repeated. `pwm` (PWM_BITS bits) free-runs every clock. All LEDS bits = `(pwm < duty)`. Init: `duty = 0`, rising.
- Initial `LEDS` after a mode switch: Count 0, Bounce 1, Gray 0, Breathe 0.
- State registers not belonging to the current mode hold their values. They are reinitialised on entry to their mode.

## Timing
- Reset values (the edge with `RESET = 1`): `presc = 0`, `cur_mode = 0`, `cnt = 0`, `pos = 0`, `dir = up`, `duty = 0`, `pwm = 0`, `LEDS = 0`. `TICK = 0` follows from `presc = 0` (SLOW ≥ 1).
- `RESET` has priority over everything, including `PAUSE` and a simultaneous step event.
- Reset mid-pattern discards all state. The first `TICK` occurs 2^SLOW-1 cycles after the first clock edge with `RESET = 0`.
- Step latency: the edge with `TICK = 1` updates `LEDS`. The new value is visible the cycle after `TICK`.
- Breathe latency: `LEDS` reflects the `pwm`/`duty` compare registered one clock.
  - `duty = 0` gives permanently off.
  - `duty = 2^PWM_BITS-1` gives on for 2^PWM_BITS-1 of every 2^PWM_BITS clocks.
- Releasing `PAUSE` does not produce an extra step. Advance resumes at the next `TICK`.
- A `MODE` change that occurs and reverts between two ticks has no effect.

## Configuration
- Macro: `LED_PATTERN_PWM_EN`.
- Defined: Breathe mode as specified, with `pwm`/`duty` logic present.
- Undefined: no PWM logic is built. `MODE = 3` behaves as a binary down-counter: init 0, then 2^NLEDS-1, 2^NLEDS-2, …, wrapping 0 → 2^NLEDS-1, and `LEDS = cnt`.

## Test plan
Bench parameters: SLOW=2, NLEDS=5, PWM_BITS=3.
- **Reset and count:** hold RESET 3 cycles, then MODE=0 → LEDS=0 during reset; TICK at cycles 3, 7, 11 after release; LEDS 1, 2, 3 one cycle after each TICK; wraps 31 → 0 after 32 steps.
- **Bounce:** MODE=1 from reset → first step is a mode switch giving LEDS=0x01; subsequent steps give 0x02, 0x04, 0x08, 0x10, 0x08, 0x04, 0x02, 0x01, 0x02.
- **Gray:** MODE=2 → after switch LEDS=0; then 1, 3, 2, 6, 7, 5, 4; exactly one bit changes per step.
- **Pause and reset priority:**
  - PAUSE high across 3 TICKs in count mode → LEDS frozen, TICK still pulses.
  - PAUSE released → next TICK advances by exactly 1.
  - RESET asserted together with TICK → LEDS=0, presc=0.
- **Breathe (macro defined):**
  - duty=0 → LEDS=0 for all clocks.
  - duty=7 → LEDS=0x1F for 7 of every 8 clocks.
  - duty sequence over steps: 1, 2, …, 7, 6, …, 0, 1.
- **Macro undefined:** MODE=3 → LEDS 0, 31, 30, 29 on successive steps; switch to MODE=0 → LEDS=0 at switch, then 1.
